pdep_seq: RTL and testbench

//  Parallel-deposit (PDEP): inverse of the SAG extract path. Scatters the low

---
 rtl/pdep_seq.sv | 120 ++++++++++++
 tb/tb_pdep_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pdep_seq.sv
// Iterative parallel-deposit engine: scatters the low popcount(ci) bits of di
// into the set positions of ci, one mask position per clock, valid/ready on both sides.
// The result port is named dout because "do" is a reserved word.
module pdep_seq #(
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         di,
   input  logic [WIDTH-1:0]         ci,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(WIDTH):0]   cnt
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int PW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       state_s;
   logic [WIDTH-1:0] di_r;
   logic [WIDTH-1:0] di_s;
   logic [WIDTH-1:0] ci_r;
   logic [WIDTH-1:0] ci_s;
   logic [PW-1:0]    pos_r;
   logic [PW-1:0]    pos_s;
   logic [PW-1:0]    src_r;
   logic [PW-1:0]    src_s;
   logic [WIDTH-1:0] dout_s;
   logic [CW-1:0]    cnt_s;
   logic             in_ready_s;
   logic             out_valid_s;

   // Next-state and datapath update for one engine step
   always_comb begin
      state_s = state_r;
      di_s    = di_r;
      ci_s    = ci_r;
      pos_s   = pos_r;
      src_s   = src_r;
      dout_s  = dout;
      cnt_s   = cnt;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               di_s    = di;
               ci_s    = ci;
               dout_s  = '0;
               cnt_s   = '0;
               pos_s   = '0;
               src_s   = '0;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            // src wraps only after the last set bit has been consumed, so it never indexes past WIDTH-1
            if (ci_r[pos_r]) begin
               dout_s[pos_r] = di_r[src_r];
               src_s         = src_r + PW'(1);
               cnt_s         = cnt + CW'(1);
            end else begin
               dout_s[pos_r] = 1'b0;
            end
            pos_s = pos_r + PW'(1);
            if (pos_r == PW'(WIDTH - 1)) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      in_ready_s  = (state_s == IDLE);
      out_valid_s = (state_s == DONE);
   end

   // State, latched operands and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= IDLE;
         di_r      <= '0;
         ci_r      <= '0;
         pos_r     <= '0;
         src_r     <= '0;
         dout      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_r   <= state_s;
         di_r      <= di_s;
         ci_r      <= ci_s;
         pos_r     <= pos_s;
         src_r     <= src_s;
         dout      <= dout_s;
         cnt       <= cnt_s;
         in_ready  <= in_ready_s;
         out_valid <= out_valid_s;
      end
   end

endmodule

// File: tb/tb_pdep_seq.sv
// Directed plus short randomized check of pdep_seq with WIDTH=8.
module tb_pdep_seq;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] di;
   logic [7:0] ci;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] dout;
   logic [3:0] cnt;

   int checks = 0;
   int errors = 0;

   pdep_seq #(.WIDTH(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .di        (di),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .cnt       (cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // deposit model built by peeling the lowest set bit of the mask
   function automatic logic [7:0] pdep_m(input logic [7:0] d, input logic [7:0] m);
      logic [7:0] r;
      logic [7:0] mm;
      logic [7:0] low;
      r  = 8'h00;
      mm = m;
      for (int k = 0; k < 8; k++) begin
         low = mm & (~mm + 8'h01);
         if (d[k]) r = r | low;
         mm = mm & (mm - 8'h01);
      end
      return r;
   endfunction

   function automatic logic [7:0] pext_m(input logic [7:0] d, input logic [7:0] m);
      logic [7:0] r;
      int k;
      r = 8'h00;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            r[k] = d[i];
            k++;
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] popc(input logic [7:0] m);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'd0, m[i]};
      return c;
   endfunction

   // accepts an op and returns the number of edges until out_valid
   task automatic start_wait(input logic [7:0] a, input logic [7:0] m, output int lat);
      in_valid = 1'b1;
      di = a;
      ci = m;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int lat;
      int n;
      logic [31:0] rnd;
      logic [7:0] a;
      logic [7:0] m;
      logic [7:0] got_do;
      logic [3:0] got_cnt;
      logic got;
      logic hs;

      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      di = 8'h00;
      ci = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_do", {24'd0, dout}, 32'h00);
      check("rst_cnt", {28'd0, cnt}, 32'd0);

      // 1
      start_wait(8'h07, 8'hA8, lat);
      check("t1_latency", lat, 32'd8);
      check("t1_do", {24'd0, dout}, 32'hA8);
      check("t1_cnt", {28'd0, cnt}, 32'd3);
      finish_op("t1");

      // 2
      start_wait(8'h0D, 8'hF0, lat);
      check("t2a_latency", lat, 32'd8);
      check("t2a_do", {24'd0, dout}, 32'hD0);
      check("t2a_cnt", {28'd0, cnt}, 32'd4);
      finish_op("t2a");
      start_wait(8'hFF, 8'h00, lat);
      check("t2b_latency", lat, 32'd8);
      check("t2b_do", {24'd0, dout}, 32'h00);
      check("t2b_cnt", {28'd0, cnt}, 32'd0);
      finish_op("t2b");

      // 3: stall in DONE with stray in_valid pulses
      start_wait(8'h5A, 8'hFF, lat);
      check("t3_latency", lat, 32'd8);
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         di = 8'h33;
         ci = 8'h0F;
         tick();
         check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
         check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
         check("t3_hold_do", {24'd0, dout}, 32'h5A);
         check("t3_hold_cnt", {28'd0, cnt}, 32'd8);
      end
      in_valid = 1'b0;
      finish_op("t3");

      // 4: reset mid-run
      in_valid = 1'b1;
      di = 8'h03;
      ci = 8'h81;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t4_in_ready", {31'd0, in_ready}, 32'd1);
      check("t4_out_valid", {31'd0, out_valid}, 32'd0);
      check("t4_do", {24'd0, dout}, 32'h00);
      check("t4_cnt", {28'd0, cnt}, 32'd0);
      start_wait(8'h01, 8'h10, lat);
      check("t4_latency", lat, 32'd8);
      check("t4_do2", {24'd0, dout}, 32'h10);
      check("t4_cnt2", {28'd0, cnt}, 32'd1);
      finish_op("t4");

      // 5: inputs churn during RUN
      in_valid = 1'b1;
      di = 8'h06;
      ci = 8'h66;
      tick();
      n = 0;
      while (!out_valid && n < 20) begin
         rnd = $urandom;
         di = rnd[7:0];
         ci = rnd[15:8];
         in_valid = rnd[16];
         tick();
         n++;
      end
      in_valid = 1'b0;
      check("t5_latency", n, 32'd8);
      check("t5_do", {24'd0, dout}, 32'h24);
      check("t5_cnt", {28'd0, cnt}, 32'd4);
      finish_op("t5");

      // 6: randomized ops with random consumer stalls
      for (int op = 0; op < 300; op++) begin
         rnd = $urandom;
         a = rnd[7:0];
         m = rnd[15:8];
         repeat ($urandom_range(0, 2)) tick();
         in_valid = 1'b1;
         di = a;
         ci = m;
         tick();
         in_valid = 1'b0;
         rnd = $urandom;
         di = rnd[7:0];
         ci = rnd[15:8];
         got = 1'b0;
         got_do = 8'h00;
         got_cnt = 4'd0;
         n = 0;
         while (!got && n < 60) begin
            out_ready = ($urandom_range(0, 1) == 1);
            hs = out_valid && out_ready;
            if (hs) begin
               got_do = dout;
               got_cnt = cnt;
            end
            tick();
            n++;
            if (hs) got = 1'b1;
         end
         out_ready = 1'b0;
         check("r_got", {31'd0, got}, 32'd1);
         check("r_do", {24'd0, got_do}, {24'd0, pdep_m(a, m)});
         check("r_cnt", {28'd0, got_cnt}, {28'd0, popc(m)});
         check("r_pext", {24'd0, pext_m(got_do, m)}, {24'd0, a & 8'((9'd1 << popc(m)) - 9'd1)});
         check("r_no_dup", {31'd0, out_valid}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
